// File: rtl/writeback_cycle.sv
// Write-back stage with SECDED decode of the selected result, sticky FAULT state and capture log.
// Optional corrected-error counter enabled by defining WB_ECC_COUNT_EN (otherwise ce_count is tied to 0).
module writeback_cycle #(
  parameter int CE_CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RegWriteW,
  input  logic                ResultSrcW,
  input  logic                JumpW,
  input  logic [4:0]          RD_W,
  input  logic [38:0]         ALU_ResultW_ECC,
  input  logic [38:0]         ReadDataW_ECC,
  input  logic [38:0]         PCPlus4W_ECC,
  input  logic                fault_clr,
  output logic                RF_WE,
  output logic [4:0]          RF_RD,
  output logic [31:0]         ResultW,
  output logic                ce_pulse,
  output logic                fault_irq,
  output logic                halt,
  output logic [4:0]          log_rd,
  output logic [1:0]          log_src,
  output logic [5:0]          log_syn,
  output logic [CE_CNT_W-1:0] ce_count
);

  localparam logic [0:0] S_NORMAL = 1'b0;
  localparam logic [0:0] S_FAULT  = 1'b1;

  // Hamming position holding data bit k (non-power-of-two positions, ascending).
  function automatic int data_pos(input int k);
    int n;
    int res;
    n   = 0;
    res = 0;
    for (int i = 1; i < 39; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (n == k) res = i;
        n++;
      end
    end
    return res;
  endfunction

  logic [38:0] w_code;
  logic [38:0] w_corr;
  logic [5:0]  w_syn;
  logic        w_par;
  logic        w_ce;
  logic        w_ded;
  logic [1:0]  w_src;
  logic [31:0] w_data;

  logic [0:0]  r_state;
  logic [4:0]  r_log_rd;
  logic [1:0]  r_log_src;
  logic [5:0]  r_log_syn;

  assign w_code = JumpW ? PCPlus4W_ECC : (ResultSrcW ? ReadDataW_ECC : ALU_ResultW_ECC);
  assign w_src  = JumpW ? 2'd2 : (ResultSrcW ? 2'd1 : 2'd0);
  assign w_par  = ^w_code;

  always_comb begin
    w_syn = '0;
    for (int i = 1; i < 39; i++) begin
      if (w_code[i]) w_syn = w_syn ^ 6'(i);
    end
  end

  // Flipping code[0] or any position up to 38 is a correctable single error.
  always_comb begin
    w_corr = w_code;
    if (w_par && (w_syn != 6'd0) && (w_syn <= 6'd38))
      w_corr = w_code ^ (39'd1 << w_syn);
  end

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_extract
      assign w_data[gi] = w_corr[data_pos(gi)];
    end
  endgenerate

  assign w_ce  = RegWriteW & w_par & (w_syn <= 6'd38);
  assign w_ded = RegWriteW & ((w_par & (w_syn > 6'd38)) | (~w_par & (w_syn != 6'd0)));

  assign RF_WE    = RegWriteW & (RD_W != 5'd0) & ~w_ded & (r_state == S_NORMAL);
  assign RF_RD    = RD_W;
  assign ResultW  = w_data;
  assign ce_pulse = w_ce;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_NORMAL;
      r_log_rd  <= '0;
      r_log_src <= '0;
      r_log_syn <= '0;
    end else begin
      // A DED recaptures the log on entry, or when it coincides with fault_clr.
      if (w_ded && ((r_state == S_NORMAL) || fault_clr)) begin
        r_state   <= S_FAULT;
        r_log_rd  <= RD_W;
        r_log_src <= w_src;
        r_log_syn <= w_syn;
      end else if ((r_state == S_FAULT) && fault_clr) begin
        r_state <= S_NORMAL;
      end
    end
  end

  assign fault_irq = (r_state == S_FAULT);
  assign halt      = fault_irq;
  assign log_rd    = r_log_rd;
  assign log_src   = r_log_src;
  assign log_syn   = r_log_syn;

`ifdef WB_ECC_COUNT_EN
  logic [CE_CNT_W-1:0] r_ce_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ce_count <= '0;
    end else if (w_ce && (r_state == S_NORMAL) && (r_ce_count != '1)) begin
      r_ce_count <= r_ce_count + 1'b1;
    end
  end

  assign ce_count = r_ce_count;
`else
  assign ce_count = '0;
`endif

endmodule

// File: tb/tb_writeback_cycle.sv
// Scoreboard bench for writeback_cycle: directed vectors push expectations, a negedge monitor pops and compares.
module tb_writeback_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteW;
  logic        ResultSrcW;
  logic        JumpW;
  logic [4:0]  RD_W;
  logic [38:0] ALU_ResultW_ECC;
  logic [38:0] ReadDataW_ECC;
  logic [38:0] PCPlus4W_ECC;
  logic        fault_clr;
  logic        RF_WE;
  logic [4:0]  RF_RD;
  logic [31:0] ResultW;
  logic        ce_pulse;
  logic        fault_irq;
  logic        halt;
  logic [4:0]  log_rd;
  logic [1:0]  log_src;
  logic [5:0]  log_syn;
  logic [15:0] ce_count;

  writeback_cycle #(.CE_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .JumpW(JumpW),
    .RD_W(RD_W), .ALU_ResultW_ECC(ALU_ResultW_ECC), .ReadDataW_ECC(ReadDataW_ECC),
    .PCPlus4W_ECC(PCPlus4W_ECC), .fault_clr(fault_clr), .RF_WE(RF_WE), .RF_RD(RF_RD),
    .ResultW(ResultW), .ce_pulse(ce_pulse), .fault_irq(fault_irq), .halt(halt),
    .log_rd(log_rd), .log_src(log_src), .log_syn(log_syn), .ce_count(ce_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        chk_res;
    logic        ce;
    logic        irq;
    logic [4:0]  lrd;
    logic [1:0]  lsrc;
    logic [5:0]  lsyn;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] c;
    logic        p;
    int          k;
    c = '0;
    k = 0;
    for (int i = 1; i < 39; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 6; j++) begin
      p = 1'b0;
      for (int i = 1; i < 39; i++)
        if ((((i >> j) & 1) == 1) && ((i & (i - 1)) != 0)) p = p ^ c[i];
      c[1 << j] = p;
    end
    c[0] = ^c[38:1];
    return c;
  endfunction

  function automatic logic [38:0] bit39(input int pos);
    return 39'd1 << pos;
  endfunction

  // Counter expectations collapse to zero when the counter is not built.
  function automatic logic [15:0] cexp(input int n);
`ifdef WB_ECC_COUNT_EN
    return 16'(n);
`else
    return (n == 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s actual=0x%0h expected=0x%0h", nm, fld, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "RF_WE", 32'(RF_WE), 32'(e.we));
      chk(e.nm, "RF_RD", 32'(RF_RD), 32'(e.rd));
      if (e.chk_res) chk(e.nm, "ResultW", ResultW, e.res);
      chk(e.nm, "ce_pulse", 32'(ce_pulse), 32'(e.ce));
      chk(e.nm, "fault_irq", 32'(fault_irq), 32'(e.irq));
      chk(e.nm, "halt", 32'(halt), 32'(e.irq));
      chk(e.nm, "log_rd", 32'(log_rd), 32'(e.lrd));
      chk(e.nm, "log_src", 32'(log_src), 32'(e.lsrc));
      chk(e.nm, "log_syn", 32'(log_syn), 32'(e.lsyn));
      chk(e.nm, "ce_count", 32'(ce_count), 32'(e.cnt));
      $display("txn %s: RF_WE=%0d RF_RD=%0d ResultW=0x%08h ce=%0d irq=%0d log=%0d/%0d/%0d cnt=%0d",
               e.nm, RF_WE, RF_RD, ResultW, ce_pulse, fault_irq, log_rd, log_src, log_syn, ce_count);
    end
  end

  task automatic drive(input logic rw, input logic src, input logic jmp, input logic [4:0] rd,
                       input logic [38:0] alu, input logic [38:0] rdd, input logic [38:0] pc4,
                       input logic clr);
    @(posedge clk);
    #1;
    RegWriteW       = rw;
    ResultSrcW      = src;
    JumpW           = jmp;
    RD_W            = rd;
    ALU_ResultW_ECC = alu;
    ReadDataW_ECC   = rdd;
    PCPlus4W_ECC    = pc4;
    fault_clr       = clr;
  endtask

  task automatic push(input string nm, input logic we, input logic [4:0] rd, input logic [31:0] res,
                      input logic chk_res, input logic ce, input logic irq, input logic [4:0] lrd,
                      input logic [1:0] lsrc, input logic [5:0] lsyn, input logic [15:0] cnt);
    exp_t e;
    e.nm = nm; e.we = we; e.rd = rd; e.res = res; e.chk_res = chk_res; e.ce = ce;
    e.irq = irq; e.lrd = lrd; e.lsrc = lsrc; e.lsyn = lsyn; e.cnt = cnt;
    q.push_back(e);
  endtask

  initial begin
    logic [38:0] z;
    z   = enc(32'd0);
    rst = 1'b0;
    RegWriteW = 1'b0; ResultSrcW = 1'b0; JumpW = 1'b0; RD_W = 5'd0;
    ALU_ResultW_ECC = '0; ReadDataW_ECC = '0; PCPlus4W_ECC = '0; fault_clr = 1'b0;

    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0, 1'b0);
    push("reset", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 6'd0, 16'd0);
    @(posedge clk);
    rst = 1'b1;

    drive(1'b1, 1'b0, 1'b0, 5'd5, enc(32'h0000_1234), z, z, 1'b0);
    push("clean_alu", 1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 6'd0, cexp(0));
    drive(1'b1, 1'b1, 1'b0, 5'd6, z, enc(32'hDEAD_BEEF) ^ bit39(7), z, 1'b0);
    push("ce_rd_bit7", 1'b1, 5'd6, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 6'd0, cexp(0));
    drive(1'b1, 1'b0, 1'b0, 5'd7, enc(32'h0000_0055) ^ bit39(0), z, z, 1'b0);
    push("ce_code0", 1'b1, 5'd7, 32'h0000_0055, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 6'd0, cexp(1));
    drive(1'b0, 1'b0, 1'b0, 5'd8, enc(32'h0000_0077) ^ bit39(0) ^ bit39(1), z, z, 1'b0);
    push("ded_no_regwrite", 1'b0, 5'd8, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 6'd0, cexp(2));
    drive(1'b1, 1'b1, 1'b1, 5'd1, z, enc(32'h0000_AAAA), enc(32'h0000_0100) ^ bit39(3) ^ bit39(10), 1'b0);
    push("ded_pc4", 1'b0, 5'd1, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 6'd0, cexp(2));
    drive(1'b1, 1'b0, 1'b0, 5'd3, enc(32'h0000_0033), z, z, 1'b0);
    push("fault_entered", 1'b0, 5'd3, 32'h0000_0033, 1'b1, 1'b0, 1'b1, 5'd1, 2'd2, 6'd9, cexp(2));
    drive(1'b1, 1'b0, 1'b0, 5'd3, enc(32'h0000_0044) ^ bit39(12), z, z, 1'b0);
    push("ce_in_fault", 1'b0, 5'd3, 32'h0000_0044, 1'b1, 1'b1, 1'b1, 5'd1, 2'd2, 6'd9, cexp(2));
    drive(1'b1, 1'b1, 1'b0, 5'd9, z, enc(32'h0000_0005) ^ bit39(5) ^ bit39(6), z, 1'b0);
    push("ded_in_fault", 1'b0, 5'd9, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1, 2'd2, 6'd9, cexp(2));
    drive(1'b1, 1'b0, 1'b0, 5'd12, z ^ bit39(20) ^ bit39(1), z, z, 1'b1);
    push("clr_with_ded", 1'b0, 5'd12, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1, 2'd2, 6'd9, cexp(2));
    drive(1'b1, 1'b0, 1'b0, 5'd3, enc(32'h0000_0009), z, z, 1'b0);
    push("log_recaptured", 1'b0, 5'd3, 32'h0000_0009, 1'b1, 1'b0, 1'b1, 5'd12, 2'd0, 6'd21, cexp(2));
    drive(1'b1, 1'b0, 1'b0, 5'd3, enc(32'h0000_000A), z, z, 1'b1);
    push("clr_pulse", 1'b0, 5'd3, 32'h0000_000A, 1'b1, 1'b0, 1'b1, 5'd12, 2'd0, 6'd21, cexp(2));
    drive(1'b1, 1'b0, 1'b0, 5'd3, enc(32'h1234_5678), z, z, 1'b0);
    push("write_after_clr", 1'b1, 5'd3, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 5'd12, 2'd0, 6'd21, cexp(2));
    drive(1'b1, 1'b0, 1'b0, 5'd0, enc(32'h0000_F0F0) ^ bit39(38), z, z, 1'b0);
    push("ce_rd0_bit38", 1'b0, 5'd0, 32'h0000_F0F0, 1'b1, 1'b1, 1'b0, 5'd12, 2'd0, 6'd21, cexp(2));
    drive(1'b0, 1'b0, 1'b0, 5'd0, z, z, z, 1'b0);
    push("count_rd0", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd12, 2'd0, 6'd21, cexp(3));

    // 2^16+3 corrected errors drive the counter into saturation.
    for (int n = 0; n < 65539; n++)
      drive(1'b1, 1'b1, 1'b0, 5'd0, z, enc(32'(n)) ^ bit39(17), z, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, z, z, z, 1'b0);
    push("count_saturated", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd12, 2'd0, 6'd21, cexp(16'hFFFF));

    drive(1'b1, 1'b0, 1'b0, 5'd4, z ^ bit39(1) ^ bit39(8) ^ bit39(32), z, z, 1'b0);
    push("ded_syn41", 1'b0, 5'd4, 32'd0, 1'b0, 1'b0, 1'b0, 5'd12, 2'd0, 6'd21, cexp(16'hFFFF));
    drive(1'b0, 1'b0, 1'b0, 5'd0, z, z, z, 1'b0);
    push("fault_syn41", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd4, 2'd0, 6'd41, cexp(16'hFFFF));

    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0, 1'b0);
    rst = 1'b0;
    push("reset_in_fault", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 6'd0, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'd2, enc(32'hCAFE_0001), z, z, 1'b0);
    push("write_after_reset", 1'b1, 5'd2, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 6'd0, 16'd0);

    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
